enemy_row: RTL

ENEMY_ROW -- requirements
Module: enemy_row

---
 rtl/enemy_row_pkg.sv | 19 +
 rtl/enemy_hit_cmp.sv | 26 ++
 rtl/enemy_row.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/enemy_row_pkg.sv
// rtl/enemy_row_pkg.sv - shared geometry constants and hit FSM encoding for the enemy row
package enemy_row_pkg;

   localparam int          NUM_ENEMIES = 8;
   localparam logic [10:0] ENEMY_W     = 11'd32;
   localparam logic [10:0] ENEMY_H     = 11'd24;
   localparam logic [10:0] ENEMY_PITCH = 11'd64;
   localparam logic [9:0]  ROW_X_MAX   = 10'd160;
   localparam logic [9:0]  ROW_Y_START = 10'd32;
   localparam logic [9:0]  ROW_DROP    = 10'd16;
   localparam logic [9:0]  ROW_STEP    = 10'd2;

   typedef enum logic [1:0] {
      ST_ARMED    = 2'd0,
      ST_HIT      = 2'd1,
      ST_COOLDOWN = 2'd2
   } hit_state_e;

endpackage

// File: rtl/enemy_hit_cmp.sv
// rtl/enemy_hit_cmp.sv - one enemy box versus projectile point test
module enemy_hit_cmp
   import enemy_row_pkg::*;
(
   input  logic        en_i,
   input  logic [10:0] box_x_i,
   input  logic [9:0]  box_y_i,
   input  logic [9:0]  pt_x_i,
   input  logic [9:0]  pt_y_i,
   output logic        hit_o
);

   logic [10:0] px;
   logic [10:0] py;
   logic [10:0] by;

   // 11-bit sums keep the far box edges from wrapping near the top of the 10-bit range
   assign px = {1'b0, pt_x_i};
   assign py = {1'b0, pt_y_i};
   assign by = {1'b0, box_y_i};

   assign hit_o = en_i
                && (px >= box_x_i) && (px <= box_x_i + ENEMY_W - 11'd1)
                && (py >= by)      && (py <= by + ENEMY_H - 11'd1);

endmodule

// File: rtl/enemy_row.sv
// rtl/enemy_row.sv - marching row of enemies with projectile hit detection, scoring and respawn
module enemy_row
   import enemy_row_pkg::*;
#(
   parameter logic [23:0] STEP_DIV    = 24'd500000,
   parameter logic [9:0]  ROW_Y_LIMIT = 10'd400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] projx,
   input  logic [9:0] projy,
   input  logic       proj_exists,
   output logic       has_collided,
   output logic [7:0] alive,
   output logic [9:0] row_x,
   output logic [9:0] row_y,
   output logic [7:0] score,
   output logic       wave_clear,
   output logic       invaded
);

   hit_state_e                 state_q, state_d;
   logic [NUM_ENEMIES-1:0]     alive_q, alive_d;
   logic [9:0]                 row_x_q, row_x_d;
   logic [9:0]                 row_y_q, row_y_d;
   logic [7:0]                 score_q, score_d;
   logic                       wave_clear_q, wave_clear_d;
   logic                       invaded_q, invaded_d;
   logic                       dir_left_q, dir_left_d;
   logic [23:0]                step_cnt_q, step_cnt_d;

   logic [NUM_ENEMIES-1:0]     hit_vec;
   logic                       hit_any;
   logic [2:0]                 hit_idx;
   logic                       take_hit;
   logic                       step_tc;
   logic [10:0]                nx_right;

   for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_cmp
      enemy_hit_cmp u_cmp (
         .en_i    (proj_exists & alive_q[gi]),
         .box_x_i ({1'b0, row_x_q} + 11'(gi) * ENEMY_PITCH),
         .box_y_i (row_y_q),
         .pt_x_i  (projx),
         .pt_y_i  (projy),
         .hit_o   (hit_vec[gi])
      );
   end

   // Scanning downward lets the lowest matching index win
   always_comb begin
      hit_any = 1'b0;
      hit_idx = 3'd0;
      for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit_any = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      take_hit = 1'b0;
      case (state_q)
         ST_ARMED: begin
            if (hit_any) begin
               state_d  = ST_HIT;
               take_hit = 1'b1;
            end
         end
         ST_HIT:      state_d = ST_COOLDOWN;
         ST_COOLDOWN: if (!proj_exists) state_d = ST_ARMED;
         default:     state_d = ST_ARMED;
      endcase
   end

   assign step_tc  = (step_cnt_q == STEP_DIV - 24'd1);
   assign nx_right = {1'b0, row_x_q} + {1'b0, ROW_STEP};

   always_comb begin
      alive_d      = alive_q;
      score_d      = score_q;
      row_x_d      = row_x_q;
      row_y_d      = row_y_q;
      dir_left_d   = dir_left_q;
      step_cnt_d   = step_tc ? 24'd0 : step_cnt_q + 24'd1;
      wave_clear_d = 1'b0;

      if (step_tc && !invaded_q) begin
         if (!dir_left_q) begin
            if (nx_right >= {1'b0, ROW_X_MAX}) begin
               row_x_d    = ROW_X_MAX;
               dir_left_d = 1'b1;
               row_y_d    = row_y_q + ROW_DROP;
            end else begin
               row_x_d = nx_right[9:0];
            end
         end else begin
            if (row_x_q <= ROW_STEP) begin
               row_x_d    = 10'd0;
               dir_left_d = 1'b0;
               row_y_d    = row_y_q + ROW_DROP;
            end else begin
               row_x_d = row_x_q - ROW_STEP;
            end
         end
      end

      if (take_hit) begin
         alive_d[hit_idx] = 1'b0;
         if (score_q != 8'hFF) score_d = score_q + 8'd1;
      end

      invaded_d = invaded_q | (row_y_d >= ROW_Y_LIMIT);

      // Empty row respawns a fresh wave; the score carries over
      if (alive_q == '0) begin
         alive_d      = '1;
         row_x_d      = 10'd0;
         row_y_d      = ROW_Y_START;
         dir_left_d   = 1'b0;
         step_cnt_d   = 24'd0;
         invaded_d    = 1'b0;
         wave_clear_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_ARMED;
         alive_q      <= '1;
         row_x_q      <= 10'd0;
         row_y_q      <= ROW_Y_START;
         score_q      <= 8'd0;
         wave_clear_q <= 1'b0;
         invaded_q    <= 1'b0;
         dir_left_q   <= 1'b0;
         step_cnt_q   <= 24'd0;
      end else begin
         state_q      <= state_d;
         alive_q      <= alive_d;
         row_x_q      <= row_x_d;
         row_y_q      <= row_y_d;
         score_q      <= score_d;
         wave_clear_q <= wave_clear_d;
         invaded_q    <= invaded_d;
         dir_left_q   <= dir_left_d;
         step_cnt_q   <= step_cnt_d;
      end
   end

   assign has_collided = (state_q == ST_HIT);
   assign alive        = alive_q;
   assign row_x        = row_x_q;
   assign row_y        = row_y_q;
   assign score        = score_q;
   assign wave_clear   = wave_clear_q;
   assign invaded      = invaded_q;

endmodule
